// File: rtl/atanh_piecewise.sv
// atanh_piecewise
//
// Streaming piecewise-linear inverse hyperbolic tangent. Takes a signed Q0.7
// activation value and returns an atanh estimate in signed Q3.5. The mapping
// uses only shifts, adds and comparisons. It is a two-stage pipeline with
// valid/ready handshakes on both sides and sustains one sample per cycle.
//
// Stage 1 splits the input into sign, magnitude, segment index and the offset
// of the magnitude from its segment base. Stage 2 evaluates the segment
// polynomial on the magnitude, then applies the sign or the saturation code.
//
// Parameters:
//   SAT_MAG    magnitude code |y| at or above which the output saturates
//              (legal 125..128).
//
// Optional build macro:
//   ATANH_SAT_FLAG_EN  when defined, adds the out_sat port and its flag
//                      register. When undefined, both are absent and x_out
//                      behaves identically.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_valid   in   input sample valid
//   in_ready   out  block accepts a sample this cycle
//   y_in       in   [7:0] signed Q0.7 input
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   x_out      out  [7:0] signed Q3.5 result
//   out_sat    out  result was saturated (ATANH_SAT_FLAG_EN only)

module atanh_piecewise #(
    parameter int SAT_MAG = 127
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] y_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] x_out
`ifdef ATANH_SAT_FLAG_EN
    ,
    output logic       out_sat
`endif
);

    // Segment 6 is not a linear piece: it marks the saturated range.
    localparam logic [2:0] SEG_SAT = 3'd6;

    // Segment selection on the input magnitude.
    function automatic logic [2:0] seg_index(input logic [7:0] m);
        logic [2:0] seg;
        if (int'(m) >= SAT_MAG)  seg = SEG_SAT;
        else if (m < 8'd64)      seg = 3'd0;
        else if (m < 8'd96)      seg = 3'd1;
        else if (m < 8'd112)     seg = 3'd2;
        else if (m < 8'd120)     seg = 3'd3;
        else if (m < 8'd124)     seg = 3'd4;
        else                     seg = 3'd5;
        return seg;
    endfunction

    // Lower bound of each segment, subtracted to form the local offset.
    function automatic logic [7:0] seg_base(input logic [2:0] seg);
        logic [7:0] base;
        case (seg)
            3'd1:    base = 8'd64;
            3'd2:    base = 8'd96;
            3'd3:    base = 8'd112;
            3'd4:    base = 8'd120;
            3'd5:    base = 8'd124;
            default: base = 8'd0;
        endcase
        return base;
    endfunction

    // Magnitude result. Slopes 1/4, 1/2, 3/4, 3/2, 3 and 8 built from shifts.
    // Largest value reached is 92 (m = 127 with SAT_MAG = 128), so 9 bits
    // never wrap.
    function automatic logic [8:0] mag_result(input logic [2:0] seg,
                                              input logic [7:0] m,
                                              input logic [7:0] d);
        logic [8:0] mw;
        logic [8:0] dw;
        logic [8:0] xm;
        mw = {1'b0, m};
        dw = {1'b0, d};
        case (seg)
            3'd0:    xm = mw >> 2;
            3'd1:    xm = 9'd16 + (dw >> 1);
            3'd2:    xm = 9'd32 + (dw >> 1) + (dw >> 2);
            3'd3:    xm = 9'd44 + dw + (dw >> 1);
            3'd4:    xm = 9'd56 + (dw << 1) + dw;
            3'd5:    xm = 9'd68 + (dw << 3);
            default: xm = 9'd0;
        endcase
        return xm;
    endfunction

    // Sign application with saturation to the end codes. Saturation is
    // asymmetric: negative inputs map to -128, positive to +127.
    function automatic logic [7:0] apply_sign(input logic       s,
                                              input logic       sat,
                                              input logic [8:0] xm);
        logic [8:0] neg;
        logic [7:0] x;
        neg = 9'd0 - xm;
        if (sat)    x = s ? 8'h80 : 8'h7F;
        else if (s) x = neg[7:0];
        else        x = xm[7:0];
        return x;
    endfunction

    // Handshake control
    logic s1_en;
    logic s2_en;
    logic vld_p1;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !vld_p1 || s2_en;
    assign in_ready = s1_en;

    // ---- stage 0 -> 1: sign / magnitude / segment decode ----
    logic       sign_p0;
    logic [7:0] mag_p0;
    logic [2:0] seg_p0;
    logic [7:0] off_p0;

    always_comb begin
        sign_p0 = y_in[7];
        // -128 has no positive 8-bit signed twin; as unsigned it is 128.
        mag_p0  = y_in[7] ? (8'd0 - y_in) : y_in;
        seg_p0  = seg_index(mag_p0);
        off_p0  = mag_p0 - seg_base(seg_p0);
    end

    logic       sign_p1;
    logic [7:0] mag_p1;
    logic [2:0] seg_p1;
    logic [7:0] off_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (s1_en) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            sign_p1 <= sign_p0;
            mag_p1  <= mag_p0;
            seg_p1  <= seg_p0;
            off_p1  <= off_p0;
        end
    end

    // ---- stage 1 -> 2: segment evaluation and sign ----
    logic [8:0] xm_p1;
    logic       sat_p1;
    logic [7:0] x_p1;

    always_comb begin
        xm_p1  = mag_result(seg_p1, mag_p1, off_p1);
        sat_p1 = (seg_p1 == SEG_SAT);
        x_p1   = apply_sign(sign_p1, sat_p1, xm_p1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            x_out     <= 8'd0;
        end else if (s2_en) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                x_out <= x_p1;
            end
        end
    end

`ifdef ATANH_SAT_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_sat <= 1'b0;
        end else if (s2_en && vld_p1) begin
            out_sat <= sat_p1;
        end
    end
`endif

endmodule
